// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
// Fetches aligned groups of FETCH_WIDTH instructions into a circular queue
// and hands them to decode one at a time over a valid/ready handshake.
// Fetch may start mid-group when the PC is unaligned. A predicted-taken
// branch cuts the group short at the predicted slot. A flush from commit
// empties the queue and redirects the fetch PC.
// pred_slot_i is expected to stay below FETCH_WIDTH.

module fetch_queue_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     FETCH_WIDTH = 2,
    parameter int unsigned     QUEUE_DEPTH = 8,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          stall_i,
    input  logic                          flush_i,
    input  logic [XLEN-1:0]               flush_pc_i,
    input  logic                          take_branch_i,
    input  logic [((FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1)-1:0] pred_slot_i,
    input  logic [XLEN-1:0]               predicted_pc_i,
    output logic                          imem_req_o,
    output logic [XLEN-1:0]               imem_addr_o,
    input  logic [FETCH_WIDTH*XLEN-1:0]   imem_rdata_i,
    output logic [XLEN-1:0]               pc_o,
    output logic                          dec_valid_o,
    input  logic                          dec_ready_i,
    output logic [XLEN-1:0]               dec_pc_o,
    output logic [XLEN-1:0]               dec_instr_o,
    output logic                          dec_pred_taken_o,
    output logic [XLEN-1:0]               dec_pred_target_o,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] count_o
);

    // Slot index width, queue pointer width, occupancy width, group bytes.
    localparam int unsigned SW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned GB = FETCH_WIDTH * 4;

    // Architectural state.
    logic [XLEN-1:0] r_pc;
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    // Queue storage, one entry per instruction.
    logic [XLEN-1:0] r_qPc     [QUEUE_DEPTH];
    logic [XLEN-1:0] r_qInstr  [QUEUE_DEPTH];
    logic            r_qTaken  [QUEUE_DEPTH];
    logic [XLEN-1:0] r_qTarget [QUEUE_DEPTH];

    // Group geometry and fetch decision.
    logic [XLEN-1:0] w_groupBase;
    logic [SW-1:0]   w_startSlot;
    logic            w_takeValid;
    logic [SW-1:0]   w_endSlot;
    logic [SW:0]     w_enqCount;
    logic            w_hasSpace;
    logic            w_fetch;
    logic            w_decValid;
    logic            w_deq;
    logic [CW-1:0]   w_enqAmt;
    logic [CW-1:0]   w_countNext;
    logic [XLEN-1:0] w_pcNext;

    // Per-slot write controls.
    logic            w_wrEn      [FETCH_WIDTH];
    logic [PW-1:0]   w_wrIdx     [FETCH_WIDTH];
    logic            w_slotTaken [FETCH_WIDTH];

    // The group base is the PC with its in-group byte offset cleared.
    // The start slot is the word index inside the group.
    // The two low PC bits play no part in either value.
    assign w_groupBase = r_pc & ~XLEN'(GB - 1);
    assign w_startSlot = SW'((r_pc >> 2) & XLEN'(FETCH_WIDTH - 1));

    // A prediction pointing at a slot before the start slot belongs to
    // instructions we are skipping, so it is ignored.
    assign w_takeValid = take_branch_i && (pred_slot_i >= w_startSlot);
    assign w_endSlot   = w_takeValid ? pred_slot_i : SW'(FETCH_WIDTH - 1);
    assign w_enqCount  = {1'b0, w_endSlot} - {1'b0, w_startSlot} + (SW+1)'(1);

    // Free space is judged on the start-of-cycle count.
    // A dequeue in the same cycle earns no credit.
    assign w_hasSpace = (32'(QUEUE_DEPTH) - 32'(r_count)) >= 32'(FETCH_WIDTH);
    assign w_fetch    = !flush_i && !stall_i && w_hasSpace;

    // A handshake during a flush is dropped; decode discards it on its side.
    assign w_decValid  = (r_count != '0);
    assign w_deq       = w_decValid && dec_ready_i && !flush_i;
    assign w_enqAmt    = w_fetch ? CW'(w_enqCount) : '0;
    assign w_countNext = r_count + w_enqAmt - CW'(w_deq);

    // Map each group slot to its queue position.
    // Slots start..end land at tail, tail+1, ... and wrap around the ring.
    always_comb begin
        for (int k = 0; k < int'(FETCH_WIDTH); k++) begin
            w_wrEn[k]      = 1'b0;
            w_wrIdx[k]     = '0;
            w_slotTaken[k] = 1'b0;
            w_wrEn[k]      = w_fetch && (SW'(k) >= w_startSlot) && (SW'(k) <= w_endSlot);
            w_wrIdx[k]     = PW'((32'(r_tail) + 32'(k) - 32'(w_startSlot)) % QUEUE_DEPTH);
            w_slotTaken[k] = w_takeValid && (SW'(k) == w_endSlot);
        end
    end

    // Choose the next fetch PC. Priority order:
    //   1. redirect from commit
    //   2. hold when not fetching
    //   3. predicted target
    //   4. next sequential group
    always_comb begin
        w_pcNext = r_pc;
        if (flush_i) begin
            w_pcNext = flush_pc_i;
        end else if (w_fetch) begin
            if (w_takeValid) begin
                w_pcNext = predicted_pc_i;
            end else begin
                w_pcNext = w_groupBase + XLEN'(GB);
            end
        end
    end

    // Control state update.
    // Reset beats flush, and flush beats fetch and dequeue.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_pc    <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_pc    <= w_pcNext;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_pc <= w_pcNext;
            if (w_fetch) begin
                r_tail <= PW'((32'(r_tail) + 32'(w_enqCount)) % QUEUE_DEPTH);
            end
            if (w_deq) begin
                r_head <= PW'((32'(r_head) + 32'd1) % QUEUE_DEPTH);
            end
            r_count <= w_countNext;
        end
    end

    // Write the fetched slots into queue storage.
    // Only the last slot of a taken group carries the prediction.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < int'(FETCH_WIDTH); k++) begin
            if (!reset_i && w_wrEn[k]) begin
                r_qPc[w_wrIdx[k]]     <= w_groupBase + XLEN'(4 * k);
                r_qInstr[w_wrIdx[k]]  <= imem_rdata_i[k*XLEN +: XLEN];
                r_qTaken[w_wrIdx[k]]  <= w_slotTaken[k];
                r_qTarget[w_wrIdx[k]] <= w_slotTaken[k] ? predicted_pc_i : '0;
            end
        end
    end

    // Fetch-side outputs.
    assign imem_req_o  = w_fetch;
    assign imem_addr_o = w_groupBase;
    assign pc_o        = r_pc;
    assign count_o     = r_count;

    // Decode-side outputs.
    // Data is forced to zero while the queue is empty, so stale storage
    // never shows up, including right after reset.
    assign dec_valid_o       = w_decValid;
    assign dec_pc_o          = w_decValid ? r_qPc[r_head]     : '0;
    assign dec_instr_o       = w_decValid ? r_qInstr[r_head]  : '0;
    assign dec_pred_taken_o  = w_decValid ? r_qTaken[r_head]  : 1'b0;
    assign dec_pred_target_o = w_decValid ? r_qTarget[r_head] : '0;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit
// Randomized and directed stimulus for fetch_queue_unit.
// The driver keeps a behavioural model of the fetch PC and the queue
// occupancy, and pushes every instruction it expects to be enqueued into a
// scoreboard. The monitor pops the scoreboard on each decode handshake and
// compares against what the DUT presents.

module tb_fetch_queue_unit;

    localparam int          FW       = 2;
    localparam int          QD       = 8;
    localparam int          GB       = FW * 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    logic        clk;
    logic        reset_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        take_branch_i;
    logic [0:0]  pred_slot_i;
    logic [31:0] predicted_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [63:0] imemRdata;
    logic [31:0] pc_o;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] dec_pc_o;
    logic [31:0] dec_instr_o;
    logic        dec_pred_taken_o;
    logic [31:0] dec_pred_target_o;
    logic [3:0]  count_o;

    int testsRun    = 0;
    int testsFailed = 0;

    // Behavioural model state and the expected outputs for the current cycle.
    entry_t      sb[$];
    logic [31:0] mPc      = 32'h0;
    int          mCount   = 0;
    bit          mKnown   = 1'b0;
    bit          expChk   = 1'b0;
    logic [31:0] expPc    = 32'h0;
    int          expCount = 0;
    bit          expValid = 1'b0;
    bit          expReq   = 1'b0;
    logic [31:0] expAddr  = 32'h0;

    // Instruction memory returns each word's own address as its contents.
    assign imemRdata = {imem_addr_o + 32'd4, imem_addr_o};

    fetch_queue_unit #(
        .XLEN(32), .FETCH_WIDTH(FW), .QUEUE_DEPTH(QD), .RESET_PC(RESET_PC)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .stall_i(stall_i),
        .flush_i(flush_i),
        .flush_pc_i(flush_pc_i),
        .take_branch_i(take_branch_i),
        .pred_slot_i(pred_slot_i),
        .predicted_pc_i(predicted_pc_i),
        .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o),
        .imem_rdata_i(imemRdata),
        .pc_o(pc_o),
        .dec_valid_o(dec_valid_o),
        .dec_ready_i(dec_ready_i),
        .dec_pc_o(dec_pc_o),
        .dec_instr_o(dec_instr_o),
        .dec_pred_taken_o(dec_pred_taken_o),
        .dec_pred_target_o(dec_pred_target_o),
        .count_o(count_o)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs.
    // Record the outputs expected for this cycle, then advance the model.
    // The task returns at the following negedge.
    task automatic applyStimulus(input bit rst, input bit stl, input bit fl, input logic [31:0] fpc,
                                 input bit tk, input bit slot, input logic [31:0] ppc, input bit rdy);
        logic [31:0] base;
        int          s0;
        int          e;
        bit          taken;
        bit          doFetch;
        entry_t      ent;
        @(posedge clk);
        #1;
        reset_i        = rst;
        stall_i        = stl;
        flush_i        = fl;
        flush_pc_i     = fpc;
        take_branch_i  = tk;
        pred_slot_i    = slot;
        predicted_pc_i = ppc;
        dec_ready_i    = rdy;

        base     = mPc & ~32'(GB - 1);
        doFetch  = !fl && !stl && ((QD - mCount) >= FW);
        expChk   = mKnown;
        expPc    = mPc;
        expCount = mCount;
        expValid = (mCount != 0);
        expReq   = doFetch;
        expAddr  = base;

        if (rst) begin
            sb.delete();
            mPc    = RESET_PC;
            mCount = 0;
            mKnown = 1'b1;
        end else if (fl) begin
            sb.delete();
            mPc    = fpc;
            mCount = 0;
        end else begin
            s0    = int'((mPc % GB) / 4);
            taken = tk && (int'(slot) >= s0);
            e     = taken ? int'(slot) : FW - 1;
            if (doFetch) begin
                for (int s = s0; s <= e; s++) begin
                    ent.pc     = base + 32'(4 * s);
                    ent.instr  = base + 32'(4 * s);
                    ent.taken  = taken && (s == e);
                    ent.target = ent.taken ? ppc : 32'h0;
                    sb.push_back(ent);
                end
                mCount = mCount + (e - s0 + 1);
                mPc    = taken ? ppc : base + 32'(GB);
            end
            if (mCount != 0 && rdy && !doFetch) begin
                mCount = mCount - 1;
            end else if (expCount != 0 && rdy && doFetch) begin
                mCount = mCount - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic stepCycle(input bit rst, input bit stl, input bit fl, input logic [31:0] fpc, input bit rdy);
        applyStimulus(rst, stl, fl, fpc, 1'b0, 1'b0, 32'h0, rdy);
    endtask

    // Monitor.
    // Each cycle it checks the fetch-side state against the model.
    // On a decode handshake it pops the oldest expected instruction and
    // compares it with the head the DUT presents.
    always @(negedge clk) begin
        entry_t ent;
        if (expChk) begin
            checkOutput("pc_o", pc_o, expPc);
            checkOutput("count_o", 32'(count_o), expCount);
            checkOutput("dec_valid_o", 32'(dec_valid_o), 32'(expValid));
            checkOutput("imem_req_o", 32'(imem_req_o), 32'(expReq));
            checkOutput("imem_addr_o", imem_addr_o, expAddr);
            if (dec_valid_o && dec_ready_i && !flush_i && !reset_i) begin
                if (sb.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL sb_underflow: got handshake at pc %h expected no entry", dec_pc_o);
                end else begin
                    ent = sb.pop_front();
                    checkOutput("dec_pc_o", dec_pc_o, ent.pc);
                    checkOutput("dec_instr_o", dec_instr_o, ent.instr);
                    checkOutput("dec_pred_taken_o", 32'(dec_pred_taken_o), 32'(ent.taken));
                    checkOutput("dec_pred_target_o", dec_pred_target_o, ent.target);
                end
            end
        end
    end

    initial begin
        reset_i        = 1'b1;
        stall_i        = 1'b0;
        flush_i        = 1'b0;
        flush_pc_i     = 32'h0;
        take_branch_i  = 1'b0;
        pred_slot_i    = 1'b0;
        predicted_pc_i = 32'h0;
        dec_ready_i    = 1'b0;

        // Free run after reset with decode always ready.
        stepCycle(1, 0, 0, 0, 1);
        stepCycle(1, 0, 0, 0, 1);
        stepCycle(0, 0, 0, 0, 1);
        checkOutput("rst_pc", pc_o, 32'h0);
        checkOutput("rst_count", 32'(count_o), 32'd0);
        checkOutput("rst_valid", 32'(dec_valid_o), 32'd0);
        checkOutput("rst_dec_pc", dec_pc_o, 32'h0);
        checkOutput("rst_dec_instr", dec_instr_o, 32'h0);
        checkOutput("rst_req", 32'(imem_req_o), 32'd1);
        stepCycle(0, 0, 0, 0, 1);
        checkOutput("run_pc8", pc_o, 32'h8);
        checkOutput("run_count2", 32'(count_o), 32'd2);
        stepCycle(0, 0, 0, 0, 1);
        checkOutput("run_pc16", pc_o, 32'h10);
        checkOutput("run_count3", 32'(count_o), 32'd3);
        for (int i = 0; i < 12; i++) stepCycle(0, 0, 0, 0, 1);

        // Unaligned redirect: only the upper slot of the group is taken.
        stepCycle(0, 0, 1, 32'h104, 0);
        stepCycle(0, 0, 0, 0, 0);
        checkOutput("unal_addr", imem_addr_o, 32'h100);
        checkOutput("unal_count0", 32'(count_o), 32'd0);
        stepCycle(0, 0, 0, 0, 0);
        checkOutput("unal_count1", 32'(count_o), 32'd1);
        checkOutput("unal_pc", pc_o, 32'h108);
        checkOutput("unal_head", dec_pc_o, 32'h104);

        // Predicted-taken branch in slot 0.
        stepCycle(0, 0, 1, 32'h20, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h80, 0);
        checkOutput("br_pc_before", pc_o, 32'h20);
        stepCycle(0, 0, 0, 0, 0);
        checkOutput("br_count", 32'(count_o), 32'd1);
        checkOutput("br_head_pc", dec_pc_o, 32'h20);
        checkOutput("br_taken", 32'(dec_pred_taken_o), 32'd1);
        checkOutput("br_target", dec_pred_target_o, 32'h80);
        checkOutput("br_pc_after", pc_o, 32'h80);

        // Fill the queue with decode stalled, then drain two entries.
        stepCycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) stepCycle(0, 0, 0, 0, 0);
        stepCycle(0, 0, 0, 0, 0);
        checkOutput("full_count", 32'(count_o), 32'd8);
        checkOutput("full_req", 32'(imem_req_o), 32'd0);
        checkOutput("full_pc", pc_o, 32'h20);
        checkOutput("full_head", dec_pc_o, 32'h0);
        stepCycle(0, 0, 0, 0, 0);
        checkOutput("full_head_stable", dec_instr_o, 32'h0);
        stepCycle(0, 0, 0, 0, 1);
        stepCycle(0, 0, 0, 0, 1);
        checkOutput("drain_count7", 32'(count_o), 32'd7);
        checkOutput("drain_req7", 32'(imem_req_o), 32'd0);
        checkOutput("drain_head", dec_pc_o, 32'h4);
        stepCycle(0, 0, 0, 0, 0);
        checkOutput("drain_count6", 32'(count_o), 32'd6);
        checkOutput("drain_req6", 32'(imem_req_o), 32'd1);

        // Flush while full, with a handshake offered in the same cycle.
        stepCycle(0, 0, 1, 32'h200, 1);
        checkOutput("fl_count_before", 32'(count_o), 32'd8);
        stepCycle(0, 0, 0, 0, 0);
        checkOutput("fl_count", 32'(count_o), 32'd0);
        checkOutput("fl_valid", 32'(dec_valid_o), 32'd0);
        checkOutput("fl_pc", pc_o, 32'h200);
        stepCycle(0, 0, 0, 0, 0);
        checkOutput("fl_refill", 32'(count_o), 32'd2);
        checkOutput("fl_head", dec_pc_o, 32'h200);

        // Reset in the middle of operation while stalled.
        stepCycle(0, 0, 0, 0, 1);
        stepCycle(1, 1, 0, 0, 1);
        checkOutput("mid_count5", 32'(count_o), 32'd5);
        stepCycle(0, 0, 0, 0, 0);
        checkOutput("mid_count", 32'(count_o), 32'd0);
        checkOutput("mid_valid", 32'(dec_valid_o), 32'd0);
        checkOutput("mid_pc", pc_o, RESET_PC);
        stepCycle(0, 0, 0, 0, 0);
        checkOutput("mid_resume_pc", pc_o, 32'h8);
        checkOutput("mid_resume_count", 32'(count_o), 32'd2);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(bit'($urandom_range(0, 99) == 0),
                          bit'($urandom_range(0, 4) == 0),
                          bit'($urandom_range(0, 19) == 0),
                          $urandom & 32'h3ff,
                          bit'($urandom_range(0, 3) == 0),
                          bit'($urandom_range(0, 1)),
                          $urandom & 32'h3ff,
                          bit'($urandom_range(0, 9) < 7));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
